// File: rtl/pc_seq_pkg.sv
// Package: pc_seq_pkg
// Shared types and defaults for the ProgCtr sequencer of the 8-bit core.
//   seq_state_t  - sequencer FSM state encoding
//   PC_W_DEF     - default program counter / branch target width
//   CNT_W_DEF    - default cycle counter width
//   TAKEN_W      - width of the taken-branch predicate
package pc_seq_pkg;

    localparam int PC_W_DEF  = 8;
    localparam int CNT_W_DEF = 16;
    localparam int TAKEN_W   = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_STALL = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Control FSM that sequences the ProgCtr datapath. Converts the Start/Done
// handshake into ProgCtr Start/Reset/Branch controls, resolves branch
// requests with a one-cycle flush bubble, and handles halt, stall and a
// cycle watchdog. Every output is registered.
//
// Optional feature macro: PC_SEQ_BRANCH_STATS_EN adds TakenCount and
// LastTarget branch statistics outputs.
//
// Ports
//   Clk, Reset_n     clock (rising edge), synchronous active-low reset
//   Start            level; begins a run when sampled high in IDLE or DONE
//   HaltReq          decoded halt, ends the run with Timeout=0
//   StallReq         freeze request from multi-cycle memory/ALU
//   BranchReq        decoded conditional branch, qualified by CondTrue
//   CondTrue         ALU condition flag
//   UncondReq        decoded unconditional jump
//   TargetIn         branch target from decode
//   PcReset          to ProgCtr.Reset (high in IDLE)
//   PcStart          to ProgCtr.Start (high in LOAD)
//   PcBranch         to ProgCtr.Branch, one cycle per taken branch
//   PcUncond         to ProgCtr.UnconditionalBranch, qualifies PcBranch
//   PcTarget         to ProgCtr.Target, captured on a taken branch
//   PcHold           freeze ProgCtr increment (STALL and DONE)
//   Flush            squash the instruction fetched in the branch shadow
//   Busy             high in LOAD/RUN/FLUSH/STALL
//   Done             held high in DONE until the next run starts
//   Timeout          valid with Done; run ended by the watchdog
//   CycleCount       RUN/FLUSH/STALL cycles of the current run, saturating
//   TakenCount       (stats) taken branches this run, saturating
//   LastTarget       (stats) last issued PcTarget
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int PC_W       = PC_W_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MAX_CYCLES = 4096
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             HaltReq,
    input  logic             StallReq,
    input  logic             BranchReq,
    input  logic             CondTrue,
    input  logic             UncondReq,
    input  logic [PC_W-1:0]  TargetIn,
    output logic             PcReset,
    output logic             PcStart,
    output logic             PcBranch,
    output logic             PcUncond,
    output logic [PC_W-1:0]  PcTarget,
    output logic             PcHold,
    output logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             Timeout,
`ifdef PC_SEQ_BRANCH_STATS_EN
    output logic [CNT_W-1:0] TakenCount,
    output logic [PC_W-1:0]  LastTarget,
`endif
    output logic [CNT_W-1:0] CycleCount
);

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    seq_state_t         state;
    seq_state_t         state_nxt;
    logic [TAKEN_W-1:0] taken;
    logic               br_issue;
    logic               wd_expire;
    logic               counting;

    assign taken    = TAKEN_W'((BranchReq & CondTrue) | UncondReq);
    assign counting = (state == ST_RUN) || (state == ST_FLUSH) || (state == ST_STALL);

    always_comb begin
        state_nxt = state;
        br_issue  = 1'b0;
        wd_expire = 1'b0;
        case (state)
            ST_IDLE:  if (Start) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_RUN;
            ST_RUN: begin
                // Halt outranks the watchdog, which outranks stall and branch.
                if (HaltReq) begin
                    state_nxt = ST_DONE;
                end else if (CycleCount >= WD_LIMIT) begin
                    state_nxt = ST_DONE;
                    wd_expire = 1'b1;
                end else if (StallReq) begin
                    state_nxt = ST_STALL;
                end else if (taken != '0) begin
                    state_nxt = ST_FLUSH;
                    br_issue  = 1'b1;
                end
            end
            // A stall request seen here is picked up again once back in RUN.
            ST_FLUSH: state_nxt = ST_RUN;
            ST_STALL: if (!StallReq) state_nxt = ST_RUN;
            ST_DONE:  if (Start) state_nxt = ST_LOAD;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs. Level outputs are decoded from the state
    // being entered so they line up with it; Flush is decoded from the state
    // being left so that it follows PcBranch by exactly one cycle.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            PcReset    <= 1'b1;
            PcStart    <= 1'b0;
            PcBranch   <= 1'b0;
            PcUncond   <= 1'b0;
            PcTarget   <= '0;
            PcHold     <= 1'b0;
            Flush      <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Timeout    <= 1'b0;
            CycleCount <= '0;
        end else begin
            state    <= state_nxt;
            PcReset  <= (state_nxt == ST_IDLE);
            PcStart  <= (state_nxt == ST_LOAD);
            PcBranch <= br_issue;
            PcUncond <= br_issue & UncondReq;
            if (br_issue) PcTarget <= TargetIn;
            PcHold   <= (state_nxt == ST_STALL) || (state_nxt == ST_DONE);
            Flush    <= (state == ST_FLUSH);
            Busy     <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN) ||
                        (state_nxt == ST_FLUSH) || (state_nxt == ST_STALL);
            Done     <= (state_nxt == ST_DONE);

            if (state_nxt == ST_LOAD)   Timeout <= 1'b0;
            else if (wd_expire)         Timeout <= 1'b1;

            if (state_nxt == ST_LOAD)   CycleCount <= '0;
            else if (counting)          CycleCount <= sat_inc(CycleCount);
        end
    end

`ifdef PC_SEQ_BRANCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            TakenCount <= '0;
            LastTarget <= '0;
        end else begin
            if (state_nxt == ST_LOAD)   TakenCount <= '0;
            else if (br_issue)          TakenCount <= sat_inc(TakenCount);
            if (br_issue) LastTarget <= TargetIn;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench: tb_pc_sequencer
// Directed vectors with hand-computed expectations for pc_sequencer,
// built with MAX_CYCLES=16 so the watchdog is reachable in a short run.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// Optional: PC_SEQ_BRANCH_STATS_EN enables the branch statistics checks.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    localparam int PC_W  = 8;
    localparam int CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Reset_n;
    logic             Start, HaltReq, StallReq, BranchReq, CondTrue, UncondReq;
    logic [PC_W-1:0]  TargetIn;
    logic             PcReset, PcStart, PcBranch, PcUncond, PcHold, Flush;
    logic             Busy, Done, Timeout;
    logic [PC_W-1:0]  PcTarget;
    logic [CNT_W-1:0] CycleCount;
`ifdef PC_SEQ_BRANCH_STATS_EN
    logic [CNT_W-1:0] TakenCount;
    logic [PC_W-1:0]  LastTarget;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    pc_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MAX_CYCLES(16)) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .Start      (Start),
        .HaltReq    (HaltReq),
        .StallReq   (StallReq),
        .BranchReq  (BranchReq),
        .CondTrue   (CondTrue),
        .UncondReq  (UncondReq),
        .TargetIn   (TargetIn),
        .PcReset    (PcReset),
        .PcStart    (PcStart),
        .PcBranch   (PcBranch),
        .PcUncond   (PcUncond),
        .PcTarget   (PcTarget),
        .PcHold     (PcHold),
        .Flush      (Flush),
        .Busy       (Busy),
        .Done       (Done),
        .Timeout    (Timeout),
`ifdef PC_SEQ_BRANCH_STATS_EN
        .TakenCount (TakenCount),
        .LastTarget (LastTarget),
`endif
        .CycleCount (CycleCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0; Start = 1'b0; HaltReq = 1'b0; StallReq = 1'b0;
        BranchReq = 1'b0; CondTrue = 1'b0; UncondReq = 1'b0; TargetIn = '0;

        // 1. reset and start
        repeat (3) tick();
        check("rst_pcreset", PcReset, 1);
        check("rst_done", Done, 0);
        check("rst_busy", Busy, 0);
        check("rst_count", CycleCount, 0);
        check("rst_branch", PcBranch, 0);
        Reset_n = 1'b1;
        tick();
        check("idle_pcreset", PcReset, 1);
        Start = 1'b1;
        tick();
        check("load_pcstart", PcStart, 1);
        check("load_pcreset", PcReset, 0);
        Start = 1'b0;
        tick();
        check("run_pcstart", PcStart, 0);
        check("run_busy", Busy, 1);
        check("run_count0", CycleCount, 0);

        // 2. unconditional jump to 100
        UncondReq = 1'b1; TargetIn = 8'd100;
        tick();
        check("uj_branch", PcBranch, 1);
        check("uj_uncond", PcUncond, 1);
        check("uj_target", PcTarget, 100);
        check("uj_flush_early", Flush, 0);
        UncondReq = 1'b0; TargetIn = 8'd0;
        tick();
        check("uj_branch_1cyc", PcBranch, 0);
        check("uj_flush", Flush, 1);
        tick();
        check("uj_flush_1cyc", Flush, 0);
        check("uj_busy", Busy, 1);
        check("uj_count", CycleCount, 3);

        // 3. conditional branch, not taken then taken to 40
        BranchReq = 1'b1; CondTrue = 1'b0; TargetIn = 8'd55;
        tick();
        check("nt_branch", PcBranch, 0);
        BranchReq = 1'b0;
        tick();
        check("nt_flush", Flush, 0);
        check("nt_branch2", PcBranch, 0);
        BranchReq = 1'b1; CondTrue = 1'b1; TargetIn = 8'd40;
        tick();
        check("ct_branch", PcBranch, 1);
        check("ct_uncond", PcUncond, 0);
        check("ct_target", PcTarget, 40);
        BranchReq = 1'b0; CondTrue = 1'b0; TargetIn = 8'd0;
        tick();
        check("ct_flush", Flush, 1);
        check("ct_branch_off", PcBranch, 0);
        tick();

        // 4. halt and jump together: halt wins
        HaltReq = 1'b1; UncondReq = 1'b1; TargetIn = 8'd7;
        tick();
        check("halt_done", Done, 1);
        check("halt_timeout", Timeout, 0);
        check("halt_branch", PcBranch, 0);
        check("halt_busy", Busy, 0);
        check("halt_hold", PcHold, 1);
        check("halt_count", CycleCount, 9);
        HaltReq = 1'b0; UncondReq = 1'b0; TargetIn = 8'd0;
        tick();
        check("done_held", Done, 1);
        check("done_count_hold", CycleCount, 9);
        Start = 1'b1;
        tick();
        check("restart_done", Done, 0);
        check("restart_pcstart", PcStart, 1);
        check("restart_count", CycleCount, 0);
        Start = 1'b0;
        tick();

        // 5. stall for 5 cycles; halt is ignored while stalled
        StallReq = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 1) HaltReq = 1'b1;
            check($sformatf("stall_hold_%0d", i), PcHold, 1);
            check($sformatf("stall_busy_%0d", i), Busy, 1);
        end
        check("stall_count", CycleCount, 5);
        check("stall_nodone", Done, 0);
        StallReq = 1'b0; HaltReq = 1'b0;
        tick();
        check("stall_release", PcHold, 0);
        check("stall_count6", CycleCount, 6);
        StallReq = 1'b1;
        tick();
        check("stall2_hold", PcHold, 1);
        Reset_n = 1'b0;
        tick();
        check("midrst_pcreset", PcReset, 1);
        check("midrst_hold", PcHold, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_count", CycleCount, 0);
        Reset_n = 1'b1; StallReq = 1'b0;
        tick();
        check("midrst_idle", PcReset, 1);

        // 6. three taken branches then watchdog at 16 counted cycles
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        for (int b = 0; b < 3; b++) begin
            UncondReq = 1'b1; TargetIn = PC_W'(10 + b);
            tick();
            check($sformatf("wd_branch_%0d", b), PcBranch, 1);
            UncondReq = 1'b0; TargetIn = 8'd0;
            tick();
        end
        check("wd_count6", CycleCount, 6);
        repeat (9) tick();
        check("wd_not_yet", Done, 0);
        tick();
        check("wd_done", Done, 1);
        check("wd_timeout", Timeout, 1);
        check("wd_count16", CycleCount, 16);
`ifdef PC_SEQ_BRANCH_STATS_EN
        check("stats_taken", TakenCount, 3);
        check("stats_last", LastTarget, 12);
`endif
        Start = 1'b1;
        tick();
        check("wd_restart_timeout", Timeout, 0);
        check("wd_restart_done", Done, 0);
`ifdef PC_SEQ_BRANCH_STATS_EN
        check("stats_clear", TakenCount, 0);
`endif
        Start = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
